// File: rtl/mono2_emu_pkg.sv
// Shared constants, readout FSM state type and hit-word packing for the
// Monopix2 column readout emulator.
package mono2_emu_pkg;

  localparam int COL_W  = 6;
  localparam int ROW_W  = 9;
  localparam int TS_W   = 7;
  localparam int WORD_W = COL_W + ROW_W + 2 * TS_W;  // 29

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ro_state_e;

  // Hit word layout: {column, row, leading-edge BCID, trailing-edge BCID}
  function automatic logic [WORD_W-1:0] pack_hit(
    input logic [COL_W-1:0] col,
    input logic [ROW_W-1:0] row,
    input logic [TS_W-1:0]  le,
    input logic [TS_W-1:0]  te
  );
    return {col, row, le, te};
  endfunction

endpackage

// File: rtl/mono2_emu_fifo.sv
// Single-clock first-word-fall-through FIFO holding timestamped hit words.
// A push while full is accepted only when a pop happens in the same cycle.
module mono2_emu_fifo
  import mono2_emu_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = WORD_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             wr_en, rd_en;

  // Depth is a power of two, so occupancy == DEPTH is exactly the MSB
  assign full_o  = count_q[AW];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign wr_en = push_i && (!full_o || pop_i);
  assign rd_en = pop_i && !empty_o;

  // Occupancy next state from the accepted push/pop pair
  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    count_d = count_q;
    if (wr_en && !rd_en)      count_d = count_q + 1'b1;
    else if (rd_en && !wr_en) count_d = count_q - 1'b1;
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage array write port
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; emptiness comes from the pointers and count alone.
    if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/monopix2_ro_emulator.sv
// Chip-side emulator of the Monopix2 column readout periphery: timestamps hits
// with a free-running BCID, buffers them, and answers the Freeze/Read handshake
// by raising TokOut and serializing 29-bit hit words MSB first on DataOut.
module monopix2_ro_emulator
  import mono2_emu_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int WORD_BITS = 29
) (
  input  logic             ClkOut,
  input  logic             nRst,
  input  logic             ResetBcid,
  input  logic             HIT_VALID,
  input  logic [COL_W-1:0] HIT_COL,
  input  logic [ROW_W-1:0] HIT_ROW,
  input  logic [TS_W-1:0]  HIT_TOT,
  input  logic             Freeze,
  input  logic             Read,
  output logic             TokOut,
  output logic             DataOut,
  output logic [7:0]       LOST_CNT,
  output logic [TS_W-1:0]  BCID
);

  localparam int CW   = $clog2(DEPTH) + 1;
  localparam int BC_W = $clog2(WORD_BITS);

  ro_state_e            state_q, state_d;
  logic [TS_W-1:0]      bcid_q, bcid_d, hit_te;
  logic [WORD_W-1:0]    hit_word, fifo_rdata;
  logic                 fifo_full, fifo_empty;
  logic [CW-1:0]        fifo_count, fcnt_q, fcnt_d, fcnt_eff;
  logic                 freeze_q, tok_q, rd_ok, pop, drop, data_out;
  logic [7:0]           lost_q, lost_d;
  logic [WORD_BITS-1:0] shift_q;
  logic [BC_W-1:0]      bit_cnt_q;

  // Timestamping: ResetBcid overrides the free-running increment
  assign bcid_d   = ResetBcid ? '0 : bcid_q + 1'b1;
  assign hit_te   = bcid_q + HIT_TOT;  // wraps mod 128 by truncation
  assign hit_word = pack_hit(HIT_COL, HIT_ROW, bcid_q, hit_te);

  mono2_emu_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk     (ClkOut),
    .rst_n   (nRst),
    .push_i  (HIT_VALID),
    .wdata_i (hit_word),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // freeze_q is the one-cycle delayed Freeze. While it is low FCNT simply is the
  // occupancy; the cycle Freeze is first seen high the register captures that
  // occupancy (minus a same-cycle pop), so hits pushed from then on are not counted.
  assign fcnt_eff = freeze_q ? fcnt_q : fifo_count;
  assign fcnt_d   = fcnt_eff - CW'(pop);
  // The empty guard is redundant while FCNT never exceeds occupancy; kept as a safety net
  assign rd_ok    = Read && (fcnt_eff != '0) && !fifo_empty;
  assign drop     = HIT_VALID && fifo_full && !pop;
  assign lost_d   = (drop && lost_q != 8'hFF) ? lost_q + 8'd1 : lost_q;

  // Bookkeeping registers: BCID, Freeze history, frozen count, token, lost hits
  always_ff @(posedge ClkOut) begin
    if (!nRst) begin
      bcid_q   <= '0;
      freeze_q <= 1'b0;
      fcnt_q   <= '0;
      tok_q    <= 1'b0;
      lost_q   <= '0;
    end else begin
      bcid_q   <= bcid_d;
      freeze_q <= Freeze;
      fcnt_q   <= fcnt_d;
      tok_q    <= (fcnt_eff != '0);
      lost_q   <= lost_d;
    end
  end

  // Readout FSM state register
  always_ff @(posedge ClkOut) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!nRst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Readout FSM next state: one accepted Read starts a 29-bit shift
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rd_ok) state_d = SHIFT;
      SHIFT:   if (bit_cnt_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Readout FSM outputs: pop strobe in IDLE, serial bit in SHIFT
  always_comb begin
    pop      = 1'b0;
    data_out = 1'b0;
    if (state_q == IDLE) pop      = rd_ok;
    else                 data_out = shift_q[WORD_BITS-1];
  end

  // Shift register and bit counter for the word being serialized
  always_ff @(posedge ClkOut) begin
    if (!nRst) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else if (pop) begin
      shift_q   <= fifo_rdata;
      bit_cnt_q <= BC_W'(WORD_BITS - 1);
    end else if (state_q == SHIFT) begin
      shift_q   <= {shift_q[WORD_BITS-2:0], 1'b0};
      bit_cnt_q <= bit_cnt_q - 1'b1;
    end
  end

  assign TokOut   = tok_q;
  assign DataOut  = data_out;
  assign LOST_CNT = lost_q;
  assign BCID     = bcid_q;

endmodule

// File: tb/tb_monopix2_ro_emulator.sv
// Self-checking bench for monopix2_ro_emulator: reset, a table of single-hit
// words, Freeze/Read corner sequences, overflow, mid-shift reset, and a
// randomized run against a queue-based reference model.
module tb_monopix2_ro_emulator;

  localparam int DEPTH = 16;
  localparam int WB    = 29;

  logic       ClkOut, nRst, ResetBcid, HIT_VALID, Freeze, Read;
  logic [5:0] HIT_COL;
  logic [8:0] HIT_ROW;
  logic [6:0] HIT_TOT;
  logic       TokOut, DataOut;
  logic [7:0] LOST_CNT;
  logic [6:0] BCID;

  int n_vec = 0;
  int n_err = 0;

  monopix2_ro_emulator #(.DEPTH(DEPTH), .WORD_BITS(WB)) dut (
    .ClkOut    (ClkOut),
    .nRst      (nRst),
    .ResetBcid (ResetBcid),
    .HIT_VALID (HIT_VALID),
    .HIT_COL   (HIT_COL),
    .HIT_ROW   (HIT_ROW),
    .HIT_TOT   (HIT_TOT),
    .Freeze    (Freeze),
    .Read      (Read),
    .TokOut    (TokOut),
    .DataOut   (DataOut),
    .LOST_CNT  (LOST_CNT),
    .BCID      (BCID)
  );

  initial ClkOut = 1'b0;
  always #5 ClkOut = ~ClkOut;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [5:0]  col;
    logic [8:0]  row;
    logic [6:0]  tot;
    logic [6:0]  at;
    logic [28:0] exp_w;
  } vec_t;

  vec_t tbl[5];

  // reference model state for the randomized run
  logic [28:0] q_m[$];
  logic [28:0] cur_m, word_m;
  int          bcid_m, lost_m, bits_left;
  logic        hv, rb, rd, pop_m, drop_m, tok_m, exp_do;
  logic [5:0]  r_col;
  logic [8:0]  r_row;
  logic [6:0]  r_tot;
  int          rate;

  logic [28:0] w, w2;
  logic        tok2;
  int          guard;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge ClkOut);
    #1;
  endtask

  task automatic quiet();
    ResetBcid = 1'b0; HIT_VALID = 1'b0; Freeze = 1'b0; Read = 1'b0;
    HIT_COL = '0; HIT_ROW = '0; HIT_TOT = '0;
  endtask

  task automatic do_reset(input int n);
    quiet();
    nRst = 1'b0;
    repeat (n) tick();
    nRst = 1'b1;
  endtask

  task automatic hit(input logic [5:0] c, input logic [8:0] r, input logic [6:0] t);
    HIT_VALID = 1'b1; HIT_COL = c; HIT_ROW = r; HIT_TOT = t;
    tick();
    HIT_VALID = 1'b0;
  endtask

  // samples bit 28 now, bit 0 after 28 more cycles
  task automatic capture(output logic [28:0] word, output logic tok_r2);
    tok_r2 = 1'b0;
    for (int i = WB - 1; i >= 0; i--) begin
      word[i] = DataOut;
      if (i == WB - 2) tok_r2 = TokOut;
      if (i > 0) tick();
    end
  endtask

  // one-cycle Read, full word capture, then one cycle so the FSM is idle again
  task automatic read_word(output logic [28:0] word, output logic tok_r2);
    Read = 1'b1;
    tick();
    Read = 1'b0;
    capture(word, tok_r2);
    tick();
  endtask

  task automatic watch_silent(input string name, input int n);
    int ones = 0;
    repeat (n) begin
      tick();
      if (DataOut !== 1'b0) ones++;
    end
    check(name, ones, 0);
  endtask

  initial begin
    tbl[0] = '{6'd5,  9'd300, 7'd10,  7'd120, {6'd5,  9'd300, 7'd120, 7'd2}};
    tbl[1] = '{6'd55, 9'd511, 7'd127, 7'd127, {6'd55, 9'd511, 7'd127, 7'd126}};
    tbl[2] = '{6'd0,  9'd0,   7'd0,   7'd0,   {6'd0,  9'd0,   7'd0,   7'd0}};
    tbl[3] = '{6'd42, 9'd1,   7'd100, 7'd50,  {6'd42, 9'd1,   7'd50,  7'd22}};
    tbl[4] = '{6'd1,  9'd256, 7'd1,   7'd127, {6'd1,  9'd256, 7'd127, 7'd0}};

    // ---- reset with Read/Freeze/hits toggling ----
    quiet();
    nRst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      Read = i[0]; Freeze = ~i[0]; HIT_VALID = 1'b1;
      tick();
    end
    check("rst_tok",  TokOut,   0);
    check("rst_data", DataOut,  0);
    check("rst_lost", LOST_CNT, 0);
    check("rst_bcid", BCID,     0);
    quiet();
    nRst = 1'b1;
    tick();
    check("bcid_first_inc", BCID, 1);
    check("rst_fifo_empty_tok", TokOut, 0);
    repeat (5) tick();
    ResetBcid = 1'b1;
    tick();
    ResetBcid = 1'b0;
    check("resetbcid_clear", BCID, 0);
    tick();
    check("resetbcid_resume", BCID, 1);

    // ---- table of single hits: word content and TokOut fall at r+2 ----
    foreach (tbl[k]) begin
      do_reset(2);
      guard = 0;
      while (BCID !== tbl[k].at && guard < 300) begin
        tick();
        guard++;
      end
      check("tbl_bcid_reach", BCID, tbl[k].at);
      hit(tbl[k].col, tbl[k].row, tbl[k].tot);
      tick();
      Freeze = 1'b1;
      tick(); tick();
      check("tbl_tok_frozen", TokOut, 1);
      read_word(w, tok2);
      check("tbl_word", w, tbl[k].exp_w);
      check("tbl_tok_r2", tok2, 0);
      Freeze = 1'b0;
      tick();
    end

    // ---- Freeze sequence: 3 counted, 2 arriving during Freeze ----
    do_reset(2);
    hit(6'd10, 9'd1, 7'd3);
    hit(6'd11, 9'd2, 7'd3);
    hit(6'd12, 9'd3, 7'd3);
    tick();
    Freeze = 1'b1;
    tick();
    hit(6'd13, 9'd4, 7'd3);
    hit(6'd14, 9'd5, 7'd3);
    for (int k = 0; k < 3; k++) begin
      read_word(w, tok2);
      check("frz_col", w[28:23], 10 + k);
      check("frz_tok_r2", tok2, (k < 2) ? 1 : 0);
    end
    Read = 1'b1;
    tick();
    Read = 1'b0;
    watch_silent("frz_extra_read_silent", 30);
    check("frz_tok_done", TokOut, 0);
    Freeze = 1'b0;
    tick(); tick();
    check("unfreeze_tok", TokOut, 1);
    for (int k = 0; k < 2; k++) begin
      read_word(w, tok2);
      check("unfrz_col", w[28:23], 13 + k);
    end
    check("unfrz_tok_r2_last", tok2, 0);

    // ---- overflow and saturation ----
    do_reset(2);
    for (int i = 0; i < 20; i++) hit(6'(i), 9'(i), 7'd1);
    check("ovf_lost4", LOST_CNT, 4);
    check("ovf_tok", TokOut, 1);
    HIT_VALID = 1'b1; HIT_COL = 6'd33; HIT_ROW = 9'd33; Read = 1'b1;
    tick();
    HIT_VALID = 1'b0; Read = 1'b0;
    check("ovf_push_pop_no_loss", LOST_CNT, 4);
    for (int i = 0; i < 300; i++) hit(6'(i % 56), 9'(i), 7'd5);
    check("ovf_lost_sat", LOST_CNT, 255);
    read_word(w, tok2);
    check("ovf_order_col", w[28:23], 1);

    // ---- Read held high across shifts ----
    do_reset(2);
    hit(6'd20, 9'd7, 7'd2);
    hit(6'd21, 9'd8, 7'd2);
    tick(); tick();
    Read = 1'b1;
    tick();
    capture(w, tok2);
    tick();
    check("held_gap_idle", DataOut, 0);
    tick();
    capture(w2, tok2);
    check("held_word1_col", w[28:23], 20);
    check("held_word2_col", w2[28:23], 21);
    check("held_word2_row", w2[22:14], 8);
    tick();
    watch_silent("held_fcnt0_silent", 40);
    Read = 1'b0;

    // ---- nRst in the middle of a shift ----
    do_reset(2);
    hit(6'd30, 9'd3, 7'd4);
    hit(6'd31, 9'd4, 7'd4);
    tick(); tick();
    Read = 1'b1;
    tick();
    Read = 1'b0;
    repeat (13) tick();
    check("midrst_bit15", DataOut, 1);
    nRst = 1'b0;
    tick();
    check("midrst_data", DataOut, 0);
    check("midrst_tok",  TokOut,  0);
    check("midrst_bcid", BCID,    0);
    nRst = 1'b1;
    tick(); tick();
    check("midrst_fifo_empty", TokOut, 0);
    Read = 1'b1;
    tick();
    Read = 1'b0;
    watch_silent("midrst_read_silent", 30);

    // ---- randomized run against the queue model (Freeze held low) ----
    do_reset(2);
    q_m.delete();
    bcid_m = 0; lost_m = 0; bits_left = 0; cur_m = '0;
    for (int c = 0; c < 2000; c++) begin
      case (c / 500)
        0: rate = 40;
        1: rate = 20;
        2: rate = 3;
        default: rate = 40;
      endcase
      hv    = ($urandom_range(rate - 1) == 0);
      rb    = ($urandom_range(63) == 0);
      rd    = ($urandom_range(2) == 0);
      r_col = 6'($urandom_range(55));
      r_row = 9'($urandom_range(511));
      r_tot = 7'($urandom_range(127));
      HIT_VALID = hv; HIT_COL = r_col; HIT_ROW = r_row; HIT_TOT = r_tot;
      ResetBcid = rb; Read = rd;

      pop_m  = rd && (bits_left == 0) && (q_m.size() != 0);
      tok_m  = (q_m.size() != 0);
      drop_m = hv && (q_m.size() == DEPTH) && !pop_m;
      word_m = {r_col, r_row, 7'(bcid_m), 7'((bcid_m + int'(r_tot)) % 128)};

      tick();

      if (bits_left > 0) bits_left--;
      if (pop_m) begin
        cur_m     = q_m.pop_front();
        bits_left = WB;
      end
      if (hv && !drop_m) q_m.push_back(word_m);
      if (drop_m && lost_m < 255) lost_m++;
      bcid_m = rb ? 0 : (bcid_m + 1) % 128;
      exp_do = (bits_left > 0) ? cur_m[bits_left-1] : 1'b0;

      check("rnd_data", DataOut,  exp_do);
      check("rnd_tok",  TokOut,   tok_m);
      check("rnd_bcid", BCID,     bcid_m);
      check("rnd_lost", LOST_CNT, lost_m);
    end
    quiet();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
